// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window sequencer and its result buffer.
package sobel_pkg;

   localparam int unsigned PIX_W_DEFAULT   = 4;
   localparam int unsigned TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } seq_state_t;

   typedef logic [3:0][3:0][PIX_W_DEFAULT-1:0] window4_t;
   typedef logic [2:0][2:0][PIX_W_DEFAULT-1:0] window3_t;

endpackage

// File: rtl/sobel_result_buffer.sv
// Four-entry result store: one write port indexed by sub-window, one read mux for the bus.
module sobel_result_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             wr_en,
   input  logic [1:0]       wr_idx,
   input  logic [PIX_W-1:0] wr_data,
   input  logic [1:0]       rd_idx,
   output logic [PIX_W-1:0] rd_data
);

   logic [3:0][PIX_W-1:0] res;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         res <= '0;
      end else if (wr_en) begin
         res[wr_idx] <= wr_data;
      end
   end

   assign rd_data = res[rd_idx];

endmodule

// File: rtl/sobel_window_sequencer.sv
// Splits a 4x4 window into four 3x3 sub-windows for the gradient unit, collects the
// four magnitudes and serves them one per bus read.
module sobel_window_sequencer
   import sobel_pkg::*;
#(
   parameter int unsigned PIX_W   = PIX_W_DEFAULT,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         load_enable,
   input  logic [3:0][3:0][PIX_W-1:0]   pixels_in,
   output logic [2:0][2:0][PIX_W-1:0]   window_out,
   output logic                         calc_start,
   input  logic                         calc_done,
   input  logic [PIX_W-1:0]             calc_result,
   input  logic                         read_req,
   output logic                         output_enable,
   output logic [PIX_W-1:0]             pixel,
   output logic                         busy,
   output logic                         overrun,
   output logic                         timeout_err
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   seq_state_t                 state;
   logic [1:0]                 idx;
   logic [1:0]                 rd_idx;
   logic [CNT_W-1:0]           wait_cnt;
   logic [3:0][3:0][PIX_W-1:0] win;

   logic                       wait_expired;
   logic                       res_wr_en;
   logic [PIX_W-1:0]           res_wr_data;
   logic [PIX_W-1:0]           res_rd_data;

   // Sub-window sel: bit 1 offsets the row, bit 0 offsets the column.
   function automatic logic [2:0][2:0][PIX_W-1:0] sub_window(
      input logic [3:0][3:0][PIX_W-1:0] w,
      input logic [1:0]                 sel
   );
      logic [2:0][2:0][PIX_W-1:0] s;
      s = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            s[2'(r)][2'(c)] = w[2'(r + int'(sel[1]))][2'(c + int'(sel[0]))];
         end
      end
      return s;
   endfunction

   assign wait_expired = (wait_cnt == CNT_MAX);
   assign res_wr_en    = (state == WAIT) && (calc_done || wait_expired);
   assign res_wr_data  = calc_done ? calc_result : '0;

   sobel_result_buffer #(
      .PIX_W (PIX_W)
   ) u_result_buffer (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .wr_en   (res_wr_en),
      .wr_idx  (idx),
      .wr_data (res_wr_data),
      .rd_idx  (rd_idx),
      .rd_data (res_rd_data)
   );

   // Sequencer: calc_start and window_out are set on the edge that enters ISSUE.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         idx         <= '0;
         rd_idx      <= '0;
         wait_cnt    <= '0;
         win         <= '0;
         window_out  <= '0;
         calc_start  <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         calc_start <= 1'b0;
         overrun    <= load_enable && (state != IDLE);
         unique case (state)
            IDLE: begin
               if (load_enable) begin
                  win        <= pixels_in;
                  idx        <= '0;
                  window_out <= sub_window(pixels_in, 2'd0);
                  calc_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (calc_done || wait_expired) begin
                  if (!calc_done) begin
                     timeout_err <= 1'b1;
                  end
                  if (idx == 2'd3) begin
                     rd_idx <= '0;
                     state  <= DRAIN;
                  end else begin
                     idx        <= idx + 2'd1;
                     window_out <= sub_window(win, idx + 2'd1);
                     calc_start <= 1'b1;
                     state      <= ISSUE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (read_req) begin
                  rd_idx <= rd_idx + 2'd1;
                  if (rd_idx == 2'd3) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read data returns in the same cycle as the bus request.
   always_comb begin
      output_enable = 1'b0;
      pixel         = '0;
      if ((state == DRAIN) && read_req) begin
         output_enable = 1'b1;
         pixel         = res_rd_data;
      end
   end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed bench for sobel_window_sequencer: sequencing, timeout, overrun, reset and done/timeout tie.
module tb_sobel_window_sequencer;
   import sobel_pkg::*;

   localparam int unsigned PIX_W   = 4;
   localparam int unsigned TIMEOUT = 16;

   logic                       HCLK;
   logic                       HRESETn;
   logic                       load_enable;
   logic [3:0][3:0][PIX_W-1:0] pixels_in;
   logic [2:0][2:0][PIX_W-1:0] window_out;
   logic                       calc_start;
   logic                       calc_done;
   logic [PIX_W-1:0]           calc_result;
   logic                       read_req;
   logic                       output_enable;
   logic [PIX_W-1:0]           pixel;
   logic                       busy;
   logic                       overrun;
   logic                       timeout_err;

   int checks = 0;
   int errors = 0;

   window4_t pat_a;
   window4_t pat_b;

   sobel_window_sequencer #(
      .PIX_W   (PIX_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .load_enable   (load_enable),
      .pixels_in     (pixels_in),
      .window_out    (window_out),
      .calc_start    (calc_start),
      .calc_done     (calc_done),
      .calc_result   (calc_result),
      .read_req      (read_req),
      .output_enable (output_enable),
      .pixel         (pixel),
      .busy          (busy),
      .overrun       (overrun),
      .timeout_err   (timeout_err)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_window(input window4_t w);
      load_enable = 1'b1;
      pixels_in   = w;
      @(negedge HCLK);
      load_enable = 1'b0;
      pixels_in   = '0;
   endtask

   // Gradient unit stand-in: answers lat cycles after the ISSUE cycle.
   task automatic respond(input logic [PIX_W-1:0] val, input int lat);
      repeat (lat) @(negedge HCLK);
      calc_done   = 1'b1;
      calc_result = val;
      @(negedge HCLK);
      calc_done   = 1'b0;
      calc_result = '0;
   endtask

   task automatic issue_step(input string tag, input logic [PIX_W-1:0] centre,
                             input logic [PIX_W-1:0] result, input int lat);
      check({tag, "_start"}, 36'(calc_start), 36'(1));
      check({tag, "_centre"}, 36'(window_out[1][1]), 36'(centre));
      respond(result, lat);
   endtask

   task automatic read_chk(input string tag, input logic [PIX_W-1:0] exp, input logic lo);
      read_req    = 1'b1;
      load_enable = lo;
      #1;
      check({tag, "_oe"}, 36'(output_enable), 36'(1));
      check({tag, "_pixel"}, 36'(pixel), 36'(exp));
      @(negedge HCLK);
      read_req    = 1'b0;
      load_enable = 1'b0;
   endtask

   initial begin
      HRESETn     = 1'b0;
      load_enable = 1'b0;
      pixels_in   = '0;
      calc_done   = 1'b0;
      calc_result = '0;
      read_req    = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            pat_a[2'(r)][2'(c)] = 4'(r * 4 + c);
            pat_b[2'(r)][2'(c)] = 4'(15 - (r * 4 + c));
         end
      end

      // Reset state
      repeat (2) @(negedge HCLK);
      check("rst_busy", 36'(busy), 36'(0));
      check("rst_start", 36'(calc_start), 36'(0));
      check("rst_oe", 36'(output_enable), 36'(0));
      check("rst_pixel", 36'(pixel), 36'(0));
      check("rst_overrun", 36'(overrun), 36'(0));
      check("rst_tmo", 36'(timeout_err), 36'(0));
      check("rst_window", 36'(window_out), 36'(0));
      HRESETn = 1'b1;

      // Basic sequence: centres 5,6,9,10 and corners follow the sub-window offset
      load_window(pat_a);
      check("b_busy", 36'(busy), 36'(1));
      check("b_overrun", 36'(overrun), 36'(0));
      check("b0_tl", 36'(window_out[0][0]), 36'(0));
      check("b0_br", 36'(window_out[2][2]), 36'(10));
      issue_step("b0", 4'd5, 4'd5, 1);
      check("b1_tl", 36'(window_out[0][0]), 36'(1));
      check("b1_br", 36'(window_out[2][2]), 36'(11));
      issue_step("b1", 4'd6, 4'd6, 1);
      check("b2_tl", 36'(window_out[0][0]), 36'(4));
      issue_step("b2", 4'd9, 4'd9, 1);
      check("b3_br", 36'(window_out[2][2]), 36'(15));
      issue_step("b3", 4'd10, 4'd10, 1);
      check("b_drain_start", 36'(calc_start), 36'(0));
      check("b_drain_busy", 36'(busy), 36'(1));
      read_chk("b_rd0", 4'd5, 1'b0);
      read_chk("b_rd1", 4'd6, 1'b0);
      read_chk("b_rd2", 4'd9, 1'b0);
      read_chk("b_rd3", 4'd10, 1'b0);
      check("b_idle_busy", 36'(busy), 36'(0));

      // Read in IDLE and stray calc_done in IDLE
      read_req = 1'b1;
      #1;
      check("idle_rd_oe", 36'(output_enable), 36'(0));
      check("idle_rd_pixel", 36'(pixel), 36'(0));
      read_req    = 1'b0;
      calc_done   = 1'b1;
      calc_result = 4'd9;
      @(negedge HCLK);
      calc_done   = 1'b0;
      calc_result = '0;
      check("stray_done_busy", 36'(busy), 36'(0));
      check("stray_done_start", 36'(calc_start), 36'(0));

      // Timeout on idx 2, with a WAIT-time read and an overrun load
      load_window(pat_a);
      issue_step("t0", 4'd5, 4'd5, 1);
      issue_step("t1", 4'd6, 4'd6, 1);
      check("t2_start", 36'(calc_start), 36'(1));
      check("t2_centre", 36'(window_out[1][1]), 36'(9));
      for (int k = 1; k <= 17; k++) begin
         @(negedge HCLK);
         if (k == 4) begin
            read_req = 1'b1;
            #1;
            check("wait_rd_oe", 36'(output_enable), 36'(0));
            check("wait_rd_pixel", 36'(pixel), 36'(0));
            read_req = 1'b0;
         end
         if (k == 8) begin
            load_enable = 1'b1;
            pixels_in   = pat_b;
         end
         if (k == 9) begin
            check("ovr_wait_pulse", 36'(overrun), 36'(1));
            load_enable = 1'b0;
            pixels_in   = '0;
         end
         if (k == 10) begin
            check("ovr_wait_once", 36'(overrun), 36'(0));
         end
      end
      check("t_pre_tmo", 36'(timeout_err), 36'(0));
      check("t_pre_start", 36'(calc_start), 36'(0));
      @(negedge HCLK);
      check("t_tmo_set", 36'(timeout_err), 36'(1));
      issue_step("t3", 4'd10, 4'd10, 1);
      read_chk("t_rd0", 4'd5, 1'b0);
      read_chk("t_rd1", 4'd6, 1'b0);
      read_chk("t_rd2", 4'd0, 1'b0);
      read_chk("t_rd3", 4'd10, 1'b1);
      check("ovr_final_pulse", 36'(overrun), 36'(1));
      check("ovr_final_busy", 36'(busy), 36'(0));
      check("ovr_final_start", 36'(calc_start), 36'(0));
      @(negedge HCLK);
      check("ovr_final_once", 36'(overrun), 36'(0));
      check("t_tmo_sticky", 36'(timeout_err), 36'(1));

      // Reset in WAIT for idx 1
      load_window(pat_a);
      issue_step("r0", 4'd5, 4'd5, 1);
      check("r1_start", 36'(calc_start), 36'(1));
      @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      check("arst_busy", 36'(busy), 36'(0));
      check("arst_tmo", 36'(timeout_err), 36'(0));
      check("arst_window", 36'(window_out), 36'(0));
      check("arst_start", 36'(calc_start), 36'(0));
      check("arst_overrun", 36'(overrun), 36'(0));
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Clean sequence after reset; idx 1 answers exactly at count 16
      load_window(pat_b);
      issue_step("c0", 4'd10, 4'd10, 1);
      issue_step("c1", 4'd9, 4'd7, 17);
      check("tie_tmo", 36'(timeout_err), 36'(0));
      issue_step("c2", 4'd6, 4'd6, 1);
      issue_step("c3", 4'd5, 4'd5, 1);
      read_chk("c_rd0", 4'd10, 1'b0);
      read_chk("c_rd1", 4'd7, 1'b0);
      read_chk("c_rd2", 4'd6, 1'b0);
      read_chk("c_rd3", 4'd5, 1'b0);
      check("c_idle_busy", 36'(busy), 36'(0));
      check("c_tmo_clear", 36'(timeout_err), 36'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel_window_sequencer.md
# sobel_window_sequencer

Control block between the AHB slave interface and the Sobel gradient unit. It accepts a 4x4 pixel window on each `load_enable` pulse and issues the four 3x3 sub-windows to the gradient unit one at a time. It collects the four edge magnitudes and then serves them, one per bus read, on the `pixel`/`output_enable` pair that the AHB interface returns as read data. It provides sequencing, completion timeout and overrun detection, so the gradient unit stays purely combinational or pipelined.

## Interface
- `PIX_W`, 4, bits per pixel and per result
- `TIMEOUT`, 16, maximum cycles to wait for `calc_done` after `calc_start`
- `HCLK` in 1: system clock, rising edge
- `HRESETn` in 1: asynchronous, active-low reset
- `load_enable` in 1: one-cycle pulse; a new window is valid on `pixels_in`
- `pixels_in` in [3:0][3:0][PIX_W-1:0]: 4x4 window, indexed [row][col]
- `window_out` out [2:0][2:0][PIX_W-1:0]: current 3x3 sub-window to the gradient unit
- `calc_start` out 1: one-cycle pulse; `window_out` is valid
- `calc_done` in 1: gradient unit result valid
- `calc_result` in PIX_W: edge magnitude
- `read_req` in 1: the bus is reading a result this cycle
- `output_enable` out 1: `pixel` is valid for this read
- `pixel` out PIX_W: result being returned
- `busy` out 1: high in every state except IDLE
- `overrun` out 1: one-cycle pulse; a `load_enable` was dropped
- `timeout_err` out 1: sticky; a sub-window timed out since reset

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - On `load_enable`, register `pixels_in` into the window register, set `idx`=0 and go to ISSUE.
- ISSUE:
  - Drive `calc_start`=1 for exactly one cycle.
  - `window_out[r][c]` = `win[r+idx[1]][c+idx[0]]`.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - `window_out` is held stable.
  - On `calc_done`: store `calc_result` in `res[idx]`.
  - Otherwise, if the wait counter reaches `TIMEOUT`: store 0 in `res[idx]` and set `timeout_err`.
  - In either case, go to DRAIN with `rd_idx`=0 if `idx`==3; else increment `idx` and go to ISSUE.
- DRAIN:
  - `output_enable` = `read_req`; `pixel` = `res[rd_idx]` when `read_req`, else 0.
  - Each `read_req` increments `rd_idx`. The read with `rd_idx`==3 returns to IDLE.
- Outside DRAIN: `output_enable`=0 and `pixel`=0, whatever the value of `read_req`.
- `calc_done` outside WAIT is ignored.
- `load_enable` outside IDLE: the window is not captured and `overrun` pulses the next cycle.
- `calc_done` and timeout expiry in the same cycle: `calc_done` wins and `timeout_err` is not set.
- Results are PIX_W wide and stored unmodified; no arithmetic is applied.
- The wait counter is `$clog2(TIMEOUT+1)` bits and saturates.

## Timing
- Reset values:
  - State IDLE; `idx`, `rd_idx`, counter, `win` and `res` all 0.
  - `calc_start`, `output_enable`, `busy`, `overrun` and `timeout_err` are 0.
  - `pixel` and `window_out` are 0.
- Reset asserted mid-sequence returns the block to IDLE immediately and discards partial results.
- `load_enable` is sampled on edge 0; `calc_start` is high in cycle 1.
- With a gradient unit that asserts `calc_done` one cycle after `calc_start`, each sub-window takes 2 cycles. DRAIN is entered 8 cycles after the load.
- `output_enable` and `pixel` are combinational from state and `read_req`, with zero added latency. This matches the same-cycle `HREADYOUT` data phase.
- A `load_enable` in the same cycle as the final DRAIN read is an overrun. A new window is accepted from the following cycle.
- A timeout is declared after `TIMEOUT` full WAIT cycles without `calc_done`.

## Structure
- `sobel_pkg` holds:
  - the `PIX_W` default;
  - the state enum `seq_state_t`;
  - the typedefs `window4_t` ([3:0][3:0][PIX_W-1:0]) and `window3_t` ([2:0][2:0][PIX_W-1:0]).
- One sub-module, `sobel_result_buffer`:
  - a 4-entry by PIX_W register file with write port (`idx`, data, write enable);
  - a read mux on `rd_idx`;
  - clears on reset.
- The FSM, counters and sub-window mux stay in the top module.

## Test plan
- **Basic sequence.**
  - Stimulus: load `pixels_in[r][c]`=r*4+c; gradient model returns the sub-window centre one cycle after `calc_start`.
  - Required: `window_out[1][1]` = 5, 6, 9, 10 across the four issues.
  - Required: four reads return 5, 6, 9, 10 with `output_enable`=1, then the block is in IDLE.
- **Timeout.**
  - Stimulus: gradient model never answers for `idx`=2.
  - Required: after 16 WAIT cycles, `res[2]`=0 and `timeout_err`=1 (sticky).
  - Required: reads return 5, 6, 0, 10.
- **Overrun.**
  - Stimulus: `load_enable` during WAIT.
  - Required: `overrun` pulses once and the window is unchanged.
  - Stimulus: `load_enable` coincident with the final read.
  - Required: `overrun` pulses once.
- **Read outside DRAIN.**
  - Stimulus: `read_req`=1 in IDLE and in WAIT.
  - Required: `output_enable`=0 and `pixel`=0.
  - Stimulus: stray `calc_done` in IDLE.
  - Required: no effect.
- **Reset mid-operation.**
  - Stimulus: drop `HRESETn` in WAIT for `idx`=1.
  - Required: all outputs return to their reset values asynchronously.
  - Required: the next load produces a clean 4-result sequence.
- **Done/timeout tie.**
  - Stimulus: `calc_done` arrives exactly at count 16.
  - Required: `calc_result` (e.g. 7) is stored and `timeout_err` stays 0.
